// File: rtl/sequential_multiplier_module.sv
// ---------------------------------------------------------------------------
// sequential_multiplier_module
//
// Purpose:
//   Multi-cycle shift-add multiplier producing the full 2*WIDTH-bit product
//   of two WIDTH-bit operands. One adder is reused across WIDTH steps, so the
//   latency is a constant WIDTH+1 cycles from accept to first out_valid.
//   Valid/ready handshakes on both the operand and the result side.
//
// Parameters:
//   WIDTH          operand width, 2..32 (product is 2*WIDTH bits)
//
// Optional feature:
//   SIGNED_MUL_EN  when defined, a/b are two's complement; magnitudes are
//                  multiplied and the result is negated when the operand
//                  signs differ. Undefined: plain unsigned multiply.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   in_valid   in   operands a/b valid
//   in_ready   out  block can accept operands (IDLE only)
//   a          in   multiplicand [WIDTH-1:0]
//   b          in   multiplier   [WIDTH-1:0]
//   out_valid  out  product valid (DONE only)
//   out_ready  in   consumer takes the product
//   product    out  registered full product [2*WIDTH-1:0]
//   busy       out  high in RUN or DONE
// ---------------------------------------------------------------------------
module sequential_multiplier_module #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int                CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  state_e               state_q;
  logic [2*WIDTH-1:0]   mcand_q;    // multiplicand, shifted left each step
  logic [WIDTH-1:0]     mplier_q;   // multiplier, shifted right each step
  logic [2*WIDTH-1:0]   acc_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   product_q;

  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [2*WIDTH-1:0]   acc_d;      // accumulator after this step's add
  logic [2*WIDTH-1:0]   result_d;   // value written to product on final step

`ifdef SIGNED_MUL_EN
  logic sign_q;

  // Magnitude of the most negative value wraps to 2^(WIDTH-1), which is
  // exactly its correct unsigned magnitude.
  assign a_mag    = a[WIDTH-1] ? WIDTH'(-a) : a;
  assign b_mag    = b[WIDTH-1] ? WIDTH'(-b) : b;
  assign result_d = sign_q ? (2*WIDTH)'(-acc_d) : acc_d;
`else
  assign a_mag    = a;
  assign b_mag    = b;
  assign result_d = acc_d;
`endif

  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Handshake outputs decode the state register only: no input-to-output path.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign product   = product_q;

  // NOTE: every register here uses non-blocking assignment so all state
  // updates see the pre-edge values; blocking would chain the shift/add.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and checked first, so it wins over any
    // handshake on the same edge and discards an in-flight result.
    if (reset) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
`ifdef SIGNED_MUL_EN
      sign_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mcand_q  <= {{WIDTH{1'b0}}, a_mag};
            mplier_q <= b_mag;
            acc_q    <= '0;
            cnt_q    <= '0;
`ifdef SIGNED_MUL_EN
            sign_q   <= a[WIDTH-1] ^ b[WIDTH-1];
`endif
            state_q  <= RUN;
          end
        end

        RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          // Step count starts at 0, so cnt_q == WIDTH-1 marks the WIDTH-th step.
          if (cnt_q == LAST) begin
            product_q <= result_d;
            state_q   <= DONE;
          end
        end

        DONE: begin
          if (out_ready) state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sequential_multiplier_module.sv
module tb_sequential_multiplier_module;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // 8-bit instance
  logic        in_valid8  = 1'b0;
  logic        out_ready8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        in_ready8, out_valid8, busy8;
  logic [15:0] product8;

  // 16-bit instance
  logic        in_valid16  = 1'b0;
  logic        out_ready16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        in_ready16, out_valid16, busy16;
  logic [31:0] product16;

  int total = 0;
  int bad   = 0;

  sequential_multiplier_module #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .product(product8), .busy(busy8)
  );

  sequential_multiplier_module #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .product(product16), .busy(busy16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer multiply of the operands as interpreted
  // (signed or unsigned), reduced modulo 2^(2w).
  function automatic longint ref_mul(input longint x, input longint y, input int w);
    longint m;
    m = (longint'(1) << (2 * w)) - 1;
`ifdef SIGNED_MUL_EN
    if (x[w-1]) x = x - (longint'(1) << w);
    if (y[w-1]) y = y - (longint'(1) << w);
`endif
    return (x * y) & m;
  endfunction

  // One full transaction on the 8-bit instance. bp = cycles out_ready is
  // held low after out_valid rises (0 = out_ready high throughout).
  // poke = toggle in_valid randomly while busy (must be ignored).
  task automatic run8(input logic [7:0] x, input logic [7:0] y, input int bp, input bit poke);
    logic [15:0] exp;
    int cyc;
    int low;
    exp = 16'(ref_mul(longint'(x), longint'(y), 8));
    @(negedge clk);
    check("accept_ready8", in_ready8, 1'b1);
    in_valid8  = 1'b1;
    a8         = x;
    b8         = y;
    out_ready8 = (bp == 0);
    @(negedge clk);
    in_valid8 = 1'b0;
    cyc = 1;
    low = 0;
    while (!out_valid8 && cyc < 50) begin
      if (!in_ready8 && busy8) low++;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      if (poke) in_valid8 = 1'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
    end
    in_valid8 = 1'b0;
    check("latency8", cyc, 9);
    check("run_busy8", low, 8);
    check("product8", product8, exp);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("bp_valid8", out_valid8, 1'b1);
      check("bp_product8", product8, exp);
      check("bp_ready8", in_ready8, 1'b0);
    end
    out_ready8 = 1'b1;
    @(negedge clk);
    check("handoff_ready8", in_ready8, 1'b1);
    check("handoff_valid8", out_valid8, 1'b0);
    out_ready8 = 1'b0;
  endtask

  task automatic run16(input logic [15:0] x, input logic [15:0] y);
    logic [31:0] exp;
    int cyc;
    exp = 32'(ref_mul(longint'(x), longint'(y), 16));
    @(negedge clk);
    check("accept_ready16", in_ready16, 1'b1);
    in_valid16  = 1'b1;
    a16         = x;
    b16         = y;
    out_ready16 = 1'b1;
    @(negedge clk);
    in_valid16 = 1'b0;
    cyc = 1;
    while (!out_valid16 && cyc < 80) begin
      @(negedge clk);
      cyc++;
    end
    check("latency16", cyc, 17);
    check("product16", product16, exp);
    @(negedge clk);
    check("handoff_ready16", in_ready16, 1'b1);
    out_ready16 = 1'b0;
  endtask

  initial begin
    int seen;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready8, 1'b1);
    check("rst_out_valid", out_valid8, 1'b0);
    check("rst_busy", busy8, 1'b0);
    check("rst_product", product8, 16'h0);
    reset = 1'b0;

    // Directed cases
    run8(8'd200, 8'd150, 0, 1'b0);
`ifndef SIGNED_MUL_EN
    check("dir_200x150", product8, 16'h7530);
`endif
    run8(8'd255, 8'd255, 0, 1'b0);
`ifndef SIGNED_MUL_EN
    check("dir_255x255", product8, 16'hFE01);
`endif
    run8(8'h00, 8'hFF, 0, 1'b1);
    check("dir_0xff", product8, 16'h0);
    run8(8'hAB, 8'h00, 0, 1'b1);
    check("dir_abx0", product8, 16'h0);
    run8(8'd77, 8'd33, 5, 1'b1);

`ifdef SIGNED_MUL_EN
    run8(8'hFD, 8'd5, 0, 1'b0);
    check("s_m3x5", product8, 16'hFFF1);
    run8(8'h80, 8'h80, 0, 1'b0);
    check("s_m128xm128", product8, 16'h4000);
    run8(8'd127, 8'h80, 0, 1'b0);
    check("s_127xm128", product8, 16'hC080);
    run8(8'd0, 8'hFF, 0, 1'b0);
    check("s_0xm1", product8, 16'h0);
`endif

    // Reset three cycles into RUN aborts the operation
    @(negedge clk);
    in_valid8  = 1'b1;
    a8         = 8'd99;
    b8         = 8'd77;
    out_ready8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_in_ready", in_ready8, 1'b1);
    check("abort_out_valid", out_valid8, 1'b0);
    check("abort_product", product8, 16'h0);
    check("abort_busy", busy8, 1'b0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid8) seen++;
    end
    check("abort_no_result", seen, 0);
    out_ready8 = 1'b0;
    run8(8'd12, 8'd13, 0, 1'b0);
    check("after_abort_12x13", product8, 16'h009C);

    // Randomized transactions
    for (int i = 0; i < 20; i++) begin
      run8(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // 16-bit instance
    run16(16'hFFFF, 16'hFFFF);
`ifndef SIGNED_MUL_EN
    check("dir16_ffffxffff", product16, 32'hFFFE0001);
`endif
    for (int i = 0; i < 5; i++) begin
      run16(16'($urandom), 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
